// File: rtl/decode_pkg.sv
// Shared decode definitions: field positions, opcode sets, instruction classes, decoded entry.
// Used by decode_fields and instr_decode_stage (optional DECODE_STATS_EN counters live in the top).
package decode_pkg;

    localparam int unsigned OPCODE_MSB = 31;
    localparam int unsigned OPCODE_LSB = 26;
    localparam int unsigned RS_MSB     = 25;
    localparam int unsigned RS_LSB     = 21;
    localparam int unsigned RT_MSB     = 20;
    localparam int unsigned RT_LSB     = 16;
    localparam int unsigned SHAMT_MSB  = 15;
    localparam int unsigned SHAMT_LSB  = 11;
    localparam int unsigned FUNC_MSB   = 4;
    localparam int unsigned FUNC_LSB   = 0;
    localparam int unsigned IMM_MSB    = 15;
    localparam int unsigned IMM_LSB    = 0;
    localparam int unsigned LABEL_MSB  = 25;
    localparam int unsigned LABEL_LSB  = 0;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LB    = 6'h20;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SB    = 6'h28;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam int unsigned NUM_I_OPS    = 14;
    localparam int unsigned NUM_J_OPS    = 2;
    localparam int unsigned NUM_ZEXT_OPS = 3;

    localparam logic [5:0] I_OPS [NUM_I_OPS] = '{
        OP_BEQ, OP_BNE, OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI,
        OP_ORI, OP_XORI, OP_LUI, OP_LB, OP_LW, OP_SB, OP_SW
    };
    localparam logic [5:0] J_OPS [NUM_J_OPS] = '{OP_J, OP_JAL};
    // Logical immediates take their operand zero-extended.
    localparam logic [5:0] ZEXT_OPS [NUM_ZEXT_OPS] = '{OP_ANDI, OP_ORI, OP_XORI};

    typedef enum logic [1:0] {
        ClassR   = 2'd0,
        ClassI   = 2'd1,
        ClassJ   = 2'd2,
        ClassIll = 2'd3
    } iclass_e;

    typedef enum logic [1:0] {
        StEmpty = 2'd0,
        StOne   = 2'd1,
        StFull  = 2'd2
    } occ_state_e;

    // Immediate is kept outside the struct because its width follows DATA_W.
    typedef struct packed {
        logic [5:0]  opcode;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  shamt;
        logic [4:0]  func;
        logic [25:0] label;
        iclass_e     iclass;
        logic        illegal;
    } entry_t;

    localparam entry_t ENTRY_RST = '{
        opcode:  6'd0,
        rs:      5'd0,
        rt:      5'd0,
        shamt:   5'd0,
        func:    5'd0,
        label:   26'd0,
        iclass:  ClassIll,
        illegal: 1'b0
    };

    function automatic logic is_i_op(input logic [5:0] op);
        logic hit;
        hit = 1'b0;
        for (int k = 0; k < NUM_I_OPS; k++) begin
            if (I_OPS[k] == op) hit = 1'b1;
        end
        return hit;
    endfunction

    function automatic logic is_j_op(input logic [5:0] op);
        logic hit;
        hit = 1'b0;
        for (int k = 0; k < NUM_J_OPS; k++) begin
            if (J_OPS[k] == op) hit = 1'b1;
        end
        return hit;
    endfunction

    function automatic logic is_zext_op(input logic [5:0] op);
        logic hit;
        hit = 1'b0;
        for (int k = 0; k < NUM_ZEXT_OPS; k++) begin
            if (ZEXT_OPS[k] == op) hit = 1'b1;
        end
        return hit;
    endfunction

endpackage

// File: rtl/decode_fields.sv
// Combinational splitter: raw instruction word -> decoded entry plus extended immediate.
// Bits of instr above 31 are ignored.
module decode_fields
    import decode_pkg::*;
#(
    parameter int unsigned INSTR_W = 32,
    parameter int unsigned DATA_W  = 32
) (
    input  logic [INSTR_W-1:0] instr,
    output entry_t             entry,
    output logic [DATA_W-1:0]  imm_ext
);

    logic [31:0] w;
    logic [5:0]  op;
    logic [15:0] imm;

    assign w   = instr[31:0];
    assign op  = w[OPCODE_MSB:OPCODE_LSB];
    assign imm = w[IMM_MSB:IMM_LSB];

    always_comb begin
        entry         = ENTRY_RST;
        entry.opcode  = op;
        entry.rs      = w[RS_MSB:RS_LSB];
        entry.rt      = w[RT_MSB:RT_LSB];
        entry.shamt   = w[SHAMT_MSB:SHAMT_LSB];
        entry.func    = w[FUNC_MSB:FUNC_LSB];
        entry.label   = w[LABEL_MSB:LABEL_LSB];
        entry.illegal = 1'b0;
        if (op == OP_RTYPE) begin
            entry.iclass = ClassR;
        end else if (is_j_op(op)) begin
            entry.iclass = ClassJ;
        end else if (is_i_op(op)) begin
            entry.iclass = ClassI;
        end else begin
            entry.iclass  = ClassIll;
            entry.illegal = 1'b1;
        end
    end

    // Everything except logical immediates sign-extends, including R/J where it is unused.
    assign imm_ext = is_zext_op(op) ? DATA_W'(imm) : DATA_W'($signed(imm));

endmodule

// File: rtl/instr_decode_stage.sv
// Registered decode stage with a 1- or 2-entry buffer, valid/ready on both sides and flush.
// Optional macro DECODE_STATS_EN adds saturating per-class delivery counters.
module instr_decode_stage
    import decode_pkg::*;
#(
    parameter int unsigned INSTR_W = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned DEPTH   = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] instr,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [5:0]         opcode,
    output logic [4:0]         rs,
    output logic [4:0]         rt,
    output logic [4:0]         shamt,
    output logic [4:0]         func,
    output logic [DATA_W-1:0]  imm_ext,
    output logic [25:0]        label,
    output logic [1:0]         iclass,
    output logic               illegal
`ifdef DECODE_STATS_EN
    ,
    output logic [15:0]        stat_r,
    output logic [15:0]        stat_i,
    output logic [15:0]        stat_j,
    output logic [15:0]        stat_ill
`endif
);

    if (INSTR_W < 32 || DATA_W < 16 || (DEPTH != 1 && DEPTH != 2)) begin : g_bad_param
        $error("instr_decode_stage: unsupported INSTR_W/DATA_W/DEPTH");
    end

    entry_t              new_entry;
    logic [DATA_W-1:0]   new_imm;

    decode_fields #(
        .INSTR_W (INSTR_W),
        .DATA_W  (DATA_W)
    ) u_decode_fields (
        .instr   (instr),
        .entry   (new_entry),
        .imm_ext (new_imm)
    );

    occ_state_e        state_q, state_d;
    entry_t            head_q, head_d, skid_q, skid_d;
    logic [DATA_W-1:0] head_imm_q, head_imm_d, skid_imm_q, skid_imm_d;
    logic              in_xfer, out_xfer;

    assign out_valid = (state_q != StEmpty);
    // A word offered during flush is dropped regardless of in_ready.
    assign in_xfer   = in_valid & in_ready & ~flush;
    assign out_xfer  = out_valid & out_ready;

    always_comb begin
        state_d    = state_q;
        head_d     = head_q;
        head_imm_d = head_imm_q;
        skid_d     = skid_q;
        skid_imm_d = skid_imm_q;
        unique case (state_q)
            StEmpty: begin
                if (in_xfer) begin
                    head_d     = new_entry;
                    head_imm_d = new_imm;
                    state_d    = StOne;
                end
            end
            StOne: begin
                if (in_xfer && out_xfer) begin
                    head_d     = new_entry;
                    head_imm_d = new_imm;
                end else if (in_xfer) begin
                    skid_d     = new_entry;
                    skid_imm_d = new_imm;
                    state_d    = (DEPTH > 1) ? StFull : StOne;
                end else if (out_xfer) begin
                    state_d = StEmpty;
                end
            end
            StFull: begin
                if (out_xfer) begin
                    head_d     = skid_q;
                    head_imm_d = skid_imm_q;
                    state_d    = StOne;
                end
            end
            default: state_d = StEmpty;
        endcase
        if (flush) state_d = StEmpty;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StEmpty;
            head_q     <= ENTRY_RST;
            head_imm_q <= '0;
            skid_q     <= ENTRY_RST;
            skid_imm_q <= '0;
        end else begin
            state_q    <= state_d;
            head_q     <= head_d;
            head_imm_q <= head_imm_d;
            skid_q     <= skid_d;
            skid_imm_q <= skid_imm_d;
        end
    end

    if (DEPTH == 1) begin : g_ready_comb
        assign in_ready = ~out_valid | out_ready;
    end else begin : g_ready_reg
        logic in_ready_q;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                in_ready_q <= 1'b1;
            end else begin
                in_ready_q <= (state_d != StFull);
            end
        end
        assign in_ready = in_ready_q;
    end

    assign opcode  = head_q.opcode;
    assign rs      = head_q.rs;
    assign rt      = head_q.rt;
    assign shamt   = head_q.shamt;
    assign func    = head_q.func;
    assign label   = head_q.label;
    assign iclass  = head_q.iclass;
    assign illegal = head_q.illegal;
    assign imm_ext = head_imm_q;

`ifdef DECODE_STATS_EN
    // Counters survive flush; only reset clears them.
    logic [15:0] stat_q [4];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 4; k++) stat_q[k] <= '0;
        end else if (out_xfer && stat_q[head_q.iclass] != 16'hFFFF) begin
            stat_q[head_q.iclass] <= stat_q[head_q.iclass] + 16'd1;
        end
    end

    assign stat_r   = stat_q[ClassR];
    assign stat_i   = stat_q[ClassI];
    assign stat_j   = stat_q[ClassJ];
    assign stat_ill = stat_q[ClassIll];
`endif

endmodule

// File: tb/tb_instr_decode_stage.sv
// Self-checking bench for instr_decode_stage: directed steps plus randomized traffic
// against a queue-based reference model.
module tb_instr_decode_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] instr = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [5:0]  opcode;
    logic [4:0]  rs, rt, shamt, func;
    logic [31:0] imm_ext;
    logic [25:0] label;
    logic [1:0]  iclass;
    logic        illegal;
`ifdef DECODE_STATS_EN
    logic [15:0] stat_r, stat_i, stat_j, stat_ill;
`endif

    int          n_tests = 0;
    int          n_fail = 0;
    logic [86:0] q[$];
    int unsigned m_stat[4] = '{default: 0};

    always #5 clk = ~clk;

    instr_decode_stage #(
        .INSTR_W (32),
        .DATA_W  (32),
        .DEPTH   (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .instr     (instr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .opcode    (opcode),
        .rs        (rs),
        .rt        (rt),
        .shamt     (shamt),
        .func      (func),
        .imm_ext   (imm_ext),
        .label     (label),
        .iclass    (iclass),
        .illegal   (illegal)
`ifdef DECODE_STATS_EN
        ,
        .stat_r    (stat_r),
        .stat_i    (stat_i),
        .stat_j    (stat_j),
        .stat_ill  (stat_ill)
`endif
    );

    function automatic logic [86:0] got();
        return {opcode, rs, rt, shamt, func, imm_ext, label, iclass, illegal};
    endfunction

    // Reference decode straight from the field/class rules.
    function automatic logic [86:0] ref_decode(input logic [31:0] w);
        logic [5:0]  op;
        logic [1:0]  cls;
        logic        ill;
        logic [31:0] imm;
        op  = w[31:26];
        ill = 1'b0;
        if (op == 6'h00) cls = 2'd0;
        else if (op inside {6'h02, 6'h03}) cls = 2'd2;
        else if (op inside {[6'h04:6'h05], [6'h08:6'h0F], 6'h20, 6'h23, 6'h28, 6'h2B}) cls = 2'd1;
        else begin
            cls = 2'd3;
            ill = 1'b1;
        end
        if (op inside {6'h0C, 6'h0D, 6'h0E}) imm = {16'h0000, w[15:0]};
        else imm = {{16{w[15]}}, w[15:0]};
        return {op, w[25:21], w[20:16], w[15:11], w[4:0], imm, w[25:0], cls, ill};
    endfunction

    function automatic logic [31:0] rand_word();
        logic [5:0] op;
        case ($urandom_range(0, 7))
            0: op = 6'h00;
            1: op = 6'h02;
            2: op = 6'h08;
            3: op = 6'h0C;
            4: op = 6'h0D;
            5: op = 6'h3F;
            6: op = 6'h23;
            default: op = 6'($urandom_range(0, 63));
        endcase
        return {op, 26'($urandom)};
    endfunction

    task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        assert (act === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Called at posedge+1 with inputs already driven: check, clock, update model.
    task automatic tick();
        bit         ix, ox;
        logic [1:0] cls;
        chk("out_valid", out_valid, q.size() != 0);
        chk("in_ready", in_ready, q.size() < 2);
        if (q.size() != 0) chk("head_fields", got(), q[0]);
`ifdef DECODE_STATS_EN
        chk("stat_r", stat_r, m_stat[0]);
        chk("stat_i", stat_i, m_stat[1]);
        chk("stat_j", stat_j, m_stat[2]);
        chk("stat_ill", stat_ill, m_stat[3]);
`endif
        @(posedge clk);
        ix = in_valid && (q.size() < 2) && !flush;
        ox = (q.size() != 0) && out_ready;
        if (ox) begin
            cls = q[0][2:1];
            if (m_stat[cls] < 32'hFFFF) m_stat[cls]++;
        end
        if (flush) begin
            q.delete();
        end else begin
            if (ox) void'(q.pop_front());
            if (ix) q.push_back(ref_decode(instr));
        end
        #1;
    endtask

    initial begin
        #12;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_fields", got(), {6'd0, 5'd0, 5'd0, 5'd0, 5'd0, 32'd0, 26'd0, 2'd3, 1'b0});
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // R-type
        out_ready = 1'b1; in_valid = 1'b1; instr = 32'h012A4020;
        tick();
        in_valid = 1'b0;
        chk("r_valid", out_valid, 1'b1);
        chk("r_opcode", opcode, 6'd0);
        chk("r_rs", rs, 5'd9);
        chk("r_rt", rt, 5'd10);
        chk("r_iclass", iclass, 2'd0);
        tick();

        // Sign- and zero-extended immediates
        in_valid = 1'b1; instr = 32'h2108FFFF;
        tick();
        in_valid = 1'b0;
        chk("addi_imm", imm_ext, 32'hFFFFFFFF);
        chk("addi_iclass", iclass, 2'd1);
        in_valid = 1'b1; instr = 32'h3000FFFF;
        tick();
        in_valid = 1'b0;
        chk("andi_imm", imm_ext, 32'h0000FFFF);
        tick();

        // Backpressure: three words, only two fit
        out_ready = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            instr = rand_word();
            if (i < 2) tick();
        end
        chk("bp_in_ready", in_ready, 1'b0);
        tick();
        out_ready = 1'b1;
        tick();
        tick();
        in_valid = 1'b0;
        repeat (3) tick();

        // Flush while FULL with a word offered
        out_ready = 1'b0; in_valid = 1'b1;
        repeat (2) begin
            instr = rand_word();
            tick();
        end
        flush = 1'b1; instr = 32'hDEADBEEF;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_full_valid", out_valid, 1'b0);
        chk("flush_full_ready", in_ready, 1'b1);
        // Flush in ONE with in_ready high still drops the offered word
        in_valid = 1'b1; instr = rand_word();
        tick();
        flush = 1'b1; instr = 32'h0C00BEEF;
        tick();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        chk("flush_one_valid", out_valid, 1'b0);
        repeat (2) tick();

        // Illegal opcode still delivered
        in_valid = 1'b1; instr = {6'h3F, 26'h0155AA5};
        tick();
        in_valid = 1'b0;
        chk("ill_flag", illegal, 1'b1);
        chk("ill_iclass", iclass, 2'd3);
        chk("ill_valid", out_valid, 1'b1);
        tick();

        // Asynchronous reset between edges
        out_ready = 1'b0; in_valid = 1'b1;
        repeat (2) begin
            instr = rand_word();
            tick();
        end
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", out_valid, 1'b0);
        chk("arst_ready", in_ready, 1'b1);
        q.delete();
        m_stat = '{default: 0};
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b1; out_ready = 1'b1; instr = 32'h012A4020;
        tick();
        in_valid = 1'b0;
        chk("post_rst_rs", rs, 5'd9);
        tick();

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 31) == 0);
            instr     = rand_word();
            tick();
        end
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (4) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
